// File: rtl/mem_arbiter_if.sv
// Bus bundle between the IF/MEM requesters, the byte-wide RAM and mem_arbiter.
// Handshake: a requester raises req with its fields valid and holds req until its one-cycle
// done pulse; fields are latched when the arbiter accepts, so later changes are ignored.
interface mem_arbiter_if #(
  parameter int ADDR_W = 17
);
  logic              if_req;
  logic [31:0]       if_addr;
  logic              if_done;
  logic [31:0]       if_inst;
  logic              mem_req;
  logic              mem_we;
  logic [31:0]       mem_addr;
  logic [1:0]        mem_size;
  logic [31:0]       mem_wdata;
  logic              mem_done;
  logic [31:0]       mem_rdata;
  logic [ADDR_W-1:0] ram_a;
  logic [7:0]        ram_dout;
  logic              ram_wr;
  logic [7:0]        ram_din;
  logic              stallreq_stop;
  logic              stallreq_start;

  modport slave (
    input  if_req, if_addr, mem_req, mem_we, mem_addr, mem_size, mem_wdata, ram_din,
    output if_done, if_inst, mem_done, mem_rdata, ram_a, ram_dout, ram_wr,
           stallreq_stop, stallreq_start
  );

  modport master (
    output if_req, if_addr, mem_req, mem_we, mem_addr, mem_size, mem_wdata, ram_din,
    input  if_done, if_inst, mem_done, mem_rdata, ram_a, ram_dout, ram_wr,
           stallreq_stop, stallreq_start
  );
endinterface

// File: rtl/mem_arbiter.sv
// Single-port byte-RAM arbiter: serialises IF word fetches and MEM 1/2/4-byte accesses, little-endian.
// Optional single-entry fetch buffer enabled by defining MEM_ARBITER_IFETCH_BUF_EN.
module mem_arbiter #(
  parameter int ADDR_W = 17
) (
  input  logic         clk,
  input  logic         rst,
  mem_arbiter_if.slave bus,
  output logic [1:0]   o_dbg_state
);
  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ACCESS = 2'd1;
  localparam logic [1:0] ST_DRAIN  = 2'd2;
  localparam logic [1:0] ST_DONE   = 2'd3;

  logic [1:0]        r_state, r_k, r_last;
  logic              r_is_mem, r_we;
  logic [ADDR_W-1:0] r_addr, r_ram_a;
  logic [31:0]       r_wdata, r_rbuf, r_if_inst, r_mem_rdata;
  logic [7:0]        r_ram_dout;
  logic              r_ram_wr, r_if_done, r_mem_done, r_stop, r_start;

  logic [ADDR_W-1:0] w_mem_addr, w_if_addr, w_next_a;
  logic [1:0]        w_mem_last, w_k_next, w_cap_idx;
  logic [7:0]        w_wbyte;
  logic [31:0]       w_rbuf_next, w_buf_word;
  logic              w_buf_hit, w_unused_hi;

  assign w_mem_addr  = bus.mem_addr[ADDR_W-1:0];
  assign w_if_addr   = bus.if_addr[ADDR_W-1:0];
  assign w_unused_hi = ^{bus.mem_addr[31:ADDR_W], bus.if_addr[31:ADDR_W]};
  assign w_mem_last  = (bus.mem_size == 2'b00) ? 2'd0 : (bus.mem_size == 2'b01) ? 2'd1 : 2'd3;
  assign w_k_next    = r_k + 2'd1;
  assign w_next_a    = r_addr + ADDR_W'(w_k_next);
  assign w_wbyte     = 8'(r_wdata >> {w_k_next, 3'b000});
  // The byte on ram_din belongs to the address driven one cycle earlier.
  assign w_cap_idx   = (r_state == ST_DRAIN) ? r_last : r_k - 2'd1;
  assign w_rbuf_next = r_rbuf | ({24'd0, bus.ram_din} << {w_cap_idx, 3'b000});

`ifdef MEM_ARBITER_IFETCH_BUF_EN
  logic              r_buf_valid;
  logic [ADDR_W-1:0] r_buf_addr, w_gap;
  logic [31:0]       r_buf_word;
  logic              w_store_hit;

  assign w_buf_hit  = r_buf_valid && (r_buf_addr == w_if_addr);
  assign w_buf_word = r_buf_word;

  // A stored byte hits the buffered word when it lies 0..3 above the buffer base, modulo the RAM size.
  always_comb begin
    w_store_hit = 1'b0;
    w_gap       = '0;
    for (int i = 0; i < 4; i++) begin
      w_gap = w_mem_addr + ADDR_W'(i) - r_buf_addr;
      if ((2'(i) <= w_mem_last) && (w_gap < ADDR_W'(4))) w_store_hit = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_buf_valid <= 1'b0;
      r_buf_addr  <= '0;
      r_buf_word  <= '0;
    end else if (r_state == ST_IDLE && bus.mem_req && bus.mem_we && w_store_hit) begin
      r_buf_valid <= 1'b0;
    end else if (r_state == ST_DRAIN && !r_is_mem) begin
      r_buf_valid <= 1'b1;
      r_buf_addr  <= r_addr;
      r_buf_word  <= w_rbuf_next;
    end
  end
`else
  assign w_buf_hit  = 1'b0;
  assign w_buf_word = '0;
`endif

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= ST_IDLE;
      r_k         <= '0;
      r_last      <= '0;
      r_is_mem    <= 1'b0;
      r_we        <= 1'b0;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_rbuf      <= '0;
      r_ram_a     <= '0;
      r_ram_dout  <= '0;
      r_ram_wr    <= 1'b0;
      r_if_done   <= 1'b0;
      r_mem_done  <= 1'b0;
      r_if_inst   <= '0;
      r_mem_rdata <= '0;
      r_stop      <= 1'b0;
      r_start     <= 1'b0;
    end else begin
      r_if_done  <= 1'b0;
      r_mem_done <= 1'b0;
      r_stop     <= 1'b0;
      r_start    <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (bus.mem_req) begin
            r_state    <= ST_ACCESS;
            r_is_mem   <= 1'b1;
            r_we       <= bus.mem_we;
            r_addr     <= w_mem_addr;
            r_last     <= w_mem_last;
            r_wdata    <= bus.mem_wdata;
            r_k        <= 2'd0;
            r_rbuf     <= '0;
            r_ram_a    <= w_mem_addr;
            r_ram_wr   <= bus.mem_we;
            r_ram_dout <= bus.mem_wdata[7:0];
            r_stop     <= 1'b1;
          end else if (bus.if_req) begin
            r_stop <= 1'b1;
            if (w_buf_hit) begin
              r_state   <= ST_DONE;
              r_if_done <= 1'b1;
              r_if_inst <= w_buf_word;
              r_start   <= 1'b1;
            end else begin
              r_state  <= ST_ACCESS;
              r_is_mem <= 1'b0;
              r_we     <= 1'b0;
              r_addr   <= w_if_addr;
              r_last   <= 2'd3;
              r_k      <= 2'd0;
              r_rbuf   <= '0;
              r_ram_a  <= w_if_addr;
              r_ram_wr <= 1'b0;
            end
          end
        end
        ST_ACCESS: begin
          if (!r_we && r_k != 2'd0) r_rbuf <= w_rbuf_next;
          if (r_k != r_last) begin
            r_k        <= w_k_next;
            r_ram_a    <= w_next_a;
            r_ram_dout <= w_wbyte;
          end else if (r_we) begin
            r_state    <= ST_DONE;
            r_ram_wr   <= 1'b0;
            r_mem_done <= 1'b1;
            r_start    <= 1'b1;
          end else begin
            r_state <= ST_DRAIN;
          end
        end
        ST_DRAIN: begin
          r_state <= ST_DONE;
          r_start <= 1'b1;
          if (r_is_mem) begin
            r_mem_done  <= 1'b1;
            r_mem_rdata <= w_rbuf_next;
          end else begin
            r_if_done <= 1'b1;
            r_if_inst <= w_rbuf_next;
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign bus.if_done        = r_if_done;
  assign bus.if_inst        = r_if_inst;
  assign bus.mem_done       = r_mem_done;
  assign bus.mem_rdata      = r_mem_rdata;
  assign bus.ram_a          = r_ram_a;
  assign bus.ram_dout       = r_ram_dout;
  assign bus.ram_wr         = r_ram_wr;
  assign bus.stallreq_stop  = r_stop;
  assign bus.stallreq_start = r_start;
  assign o_dbg_state        = r_state;
endmodule

// File: tb/tb_mem_arbiter.sv
// Self-checking bench for mem_arbiter: byte-RAM model, directed vector table, corner sequences
// and randomized traffic scored against a byte-array memory model.
module tb_mem_arbiter;
  localparam int ADDR_W = 17;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [1:0] dbg_state;

  mem_arbiter_if #(.ADDR_W(ADDR_W)) bus ();
  mem_arbiter #(.ADDR_W(ADDR_W)) dut (.clk(clk), .rst(rst), .bus(bus), .o_dbg_state(dbg_state));

  always #5 clk = ~clk;

  // RAM model with 1-cycle read latency and a preload port
  logic [7:0]        ram [0:(1<<ADDR_W)-1];
  logic              pre_en = 1'b0;
  logic [ADDR_W-1:0] pre_a = '0;
  logic [7:0]        pre_d = '0;
  always @(posedge clk) begin
    if (pre_en) ram[pre_a] <= pre_d;
    else if (bus.ram_wr) ram[bus.ram_a] <= bus.ram_dout;
    bus.ram_din <= ram[bus.ram_a];
  end

  // reference model state
  logic [7:0]        ref_mem [0:(1<<ADDR_W)-1];
  logic [ADDR_W-1:0] last_ram_a = '0;
  logic [31:0]       exp_last_rdata = '0, exp_last_inst = '0, last_if_addr = 32'h100;
`ifdef MEM_ARBITER_IFETCH_BUF_EN
  bit                m_buf_valid = 1'b0;
  logic [ADDR_W-1:0] m_buf_addr = '0;
`endif

  int n_vec = 0, n_miss = 0;

  // per-transaction capture
  logic [ADDR_W-1:0] seq_a [1:20];
  logic              seq_wr [1:20];
  logic [7:0]        seq_d [1:20];
  int                n_stop;
  logic [31:0]       h_rdata, h_inst;

  typedef struct {
    bit          is_mem;
    bit          we;
    logic [31:0] addr;
    logic [1:0]  size;
    logic [31:0] wdata;
    logic [31:0] exp_data;
    int          exp_done;
  } vec_t;
  vec_t tbl [8];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  function automatic int nbytes(input logic [1:0] s);
    return (s == 2'b00) ? 1 : (s == 2'b01) ? 2 : 4;
  endfunction

  function automatic logic [31:0] ref_read(input logic [ADDR_W-1:0] a, input int n);
    logic [31:0] v;
    logic [ADDR_W-1:0] ai;
    v = 0;
    for (int i = 0; i < n; i++) begin
      ai = a + ADDR_W'(i);
      v  = v + (32'(ref_mem[ai]) << (8 * i));
    end
    return v;
  endfunction

  function automatic bit predict_hit(input bit is_mem, input logic [ADDR_W-1:0] a);
`ifdef MEM_ARBITER_IFETCH_BUF_EN
    return !is_mem && m_buf_valid && (m_buf_addr == a);
`else
    return 1'b0;
`endif
  endfunction

  function automatic logic [31:0] rand_addr();
    int r;
    logic [ADDR_W-1:0] a;
    r = $urandom_range(0, 511);
    a = (r < 256) ? ADDR_W'(r) : ADDR_W'(32'h1FF00 + r - 256);
    return {15'($urandom), a};
  endfunction

  task automatic preload(input logic [ADDR_W-1:0] a, input logic [7:0] d);
    @(negedge clk);
    pre_en = 1'b1; pre_a = a; pre_d = d;
    ref_mem[a] = d;
  endtask

  task automatic check_zero(input string tag);
    check({tag, " if_done"}, 32'(bus.if_done), 0);
    check({tag, " if_inst"}, bus.if_inst, 0);
    check({tag, " mem_done"}, 32'(bus.mem_done), 0);
    check({tag, " mem_rdata"}, bus.mem_rdata, 0);
    check({tag, " ram_a"}, 32'(bus.ram_a), 0);
    check({tag, " ram_dout"}, 32'(bus.ram_dout), 0);
    check({tag, " ram_wr"}, 32'(bus.ram_wr), 0);
    check({tag, " stop"}, 32'(bus.stallreq_stop), 0);
    check({tag, " start"}, 32'(bus.stallreq_start), 0);
  endtask

  task automatic run_txn(input bit is_mem, input bit we, input logic [31:0] addr,
                         input logic [1:0] size, input logic [31:0] wdata,
                         output int done_c, output int start_c, output int stop_c);
    @(negedge clk);
    if (is_mem) begin
      bus.mem_req = 1'b1; bus.mem_we = we; bus.mem_addr = addr;
      bus.mem_size = size; bus.mem_wdata = wdata;
    end else begin
      bus.if_req = 1'b1; bus.if_addr = addr;
    end
    done_c = 0; start_c = 0; stop_c = 0; n_stop = 0;
    for (int c = 1; c <= 20 && done_c == 0; c++) begin
      @(negedge clk);
      if (bus.stallreq_stop) begin n_stop++; if (stop_c == 0) stop_c = c; end
      if (bus.stallreq_start) start_c = c;
      seq_a[c] = bus.ram_a; seq_wr[c] = bus.ram_wr; seq_d[c] = bus.ram_dout;
      if (is_mem ? bus.mem_done : bus.if_done) begin
        done_c = c; h_rdata = bus.mem_rdata; h_inst = bus.if_inst;
      end
      // latched fields must ignore later input changes
      bus.mem_addr = $urandom; bus.mem_wdata = $urandom; bus.if_addr = $urandom;
      bus.mem_size = 2'($urandom); bus.mem_we = 1'($urandom);
    end
    bus.mem_req = 1'b0; bus.if_req = 1'b0;
  endtask

  task automatic apply(input string name, input bit is_mem, input bit we, input logic [31:0] addr,
                       input logic [1:0] size, input logic [31:0] wdata,
                       input logic [31:0] exp_data, input int exp_done);
    int n, done_c, start_c, stop_c;
    logic [ADDR_W-1:0] a, ai;
    bit st;
    n  = is_mem ? nbytes(size) : 4;
    a  = addr[ADDR_W-1:0];
    st = is_mem && we;
    run_txn(is_mem, we, addr, size, wdata, done_c, start_c, stop_c);
    check({name, " done cycle"}, 32'(done_c), 32'(exp_done));
    check({name, " stop cycle"}, 32'(stop_c), 1);
    check({name, " stop count"}, 32'(n_stop), 1);
    check({name, " start cycle"}, 32'(start_c), 32'(exp_done));
    if (exp_done == 1) begin
      check({name, " idle ram_a"}, 32'(seq_a[1]), 32'(last_ram_a));
      check({name, " idle ram_wr"}, 32'(seq_wr[1]), 0);
    end else if (done_c > 0) begin
      for (int c = 1; c <= n && c <= done_c; c++) begin
        ai = a + ADDR_W'(c - 1);
        check({name, " ram_a"}, 32'(seq_a[c]), 32'(ai));
        check({name, " ram_wr"}, 32'(seq_wr[c]), 32'(st));
        if (st) check({name, " ram_dout"}, 32'(seq_d[c]), (wdata >> (8 * (c - 1))) & 32'hFF);
      end
      check({name, " wr in done"}, 32'(seq_wr[done_c]), 0);
      last_ram_a = a + ADDR_W'(n - 1);
    end
    if (done_c > 0) begin
      if (is_mem) check({name, " if_inst hold"}, h_inst, exp_last_inst);
      if (!is_mem || we) check({name, " mem_rdata hold"}, h_rdata, exp_last_rdata);
      if (!st) check({name, " data"}, is_mem ? h_rdata : h_inst, exp_data);
    end
    if (st) begin
      for (int i = 0; i < n; i++) begin
        ai = a + ADDR_W'(i);
        ref_mem[ai] = wdata[8*i +: 8];
`ifdef MEM_ARBITER_IFETCH_BUF_EN
        for (int j = 0; j < 4; j++)
          if (ai == m_buf_addr + ADDR_W'(j)) m_buf_valid = 1'b0;
`endif
      end
    end else if (is_mem) begin
      exp_last_rdata = exp_data;
    end else begin
      exp_last_inst = exp_data;
`ifdef MEM_ARBITER_IFETCH_BUF_EN
      m_buf_valid = 1'b1; m_buf_addr = a;
`endif
    end
  endtask

  initial begin
    int md, id, stops, starts, n;
    bit is_mem, we, hit;
    logic [1:0] size;
    logic [31:0] addr, wdata, expd, wd;
    logic [ADDR_W-1:0] a;

    bus.if_req = 0; bus.if_addr = 0; bus.mem_req = 0; bus.mem_we = 0;
    bus.mem_addr = 0; bus.mem_size = 0; bus.mem_wdata = 0;
    #1 rst = 1'b0;

    // preload both ends of the address space (wrap tests) while in reset
    for (int i = 0; i < 1024; i++) begin
      preload(ADDR_W'(i), 8'(i * 7 + 3));
      preload(ADDR_W'(32'h1FC00 + i), 8'(i * 13 + 1));
    end
    preload(17'h100, 8'h13); preload(17'h101, 8'h05);
    preload(17'h102, 8'h10); preload(17'h103, 8'h00);
    preload(17'h22, 8'h5A);  preload(17'h23, 8'h6B);
    preload(17'h1FFFE, 8'h11); preload(17'h1FFFF, 8'h80);
    preload(17'h0, 8'h22);   preload(17'h1, 8'h33);
    @(negedge clk); pre_en = 1'b0;
    check_zero("reset");
    check("reset state", 32'(dbg_state), 0);
    rst = 1'b1;

    tbl[0] = '{1'b0, 1'b0, 32'h100,      2'b10, 32'h0,        32'h00100513, 6};
    tbl[1] = '{1'b1, 1'b1, 32'h20,       2'b01, 32'hAABBCCDD, 32'h0,        3};
    tbl[2] = '{1'b1, 1'b0, 32'h0001FFFF, 2'b00, 32'h0,        32'h00000080, 3};
    tbl[3] = '{1'b1, 1'b0, 32'hFFFFFFFE, 2'b10, 32'h0,        32'h33228011, 6};
    tbl[4] = '{1'b1, 1'b0, 32'h20,       2'b11, 32'h0,        32'h6B5ACCDD, 6};
    tbl[5] = '{1'b1, 1'b0, 32'h21,       2'b01, 32'h0,        32'h00005ACC, 4};
    tbl[6] = '{1'b1, 1'b1, 32'h40,       2'b10, 32'hDEADBEEF, 32'h0,        5};
    tbl[7] = '{1'b1, 1'b0, 32'h40,       2'b10, 32'h0,        32'hDEADBEEF, 6};
    for (int i = 0; i < 8; i++)
      apply($sformatf("tbl%0d", i), tbl[i].is_mem, tbl[i].we, tbl[i].addr, tbl[i].size,
            tbl[i].wdata, tbl[i].exp_data, tbl[i].exp_done);
    check("half store ram22", 32'(ram[17'h22]), 32'h5A);
    check("half store ram21", 32'(ram[17'h21]), 32'hCC);

    // simultaneous requests: MEM first, IF accepted the cycle after DONE
    @(negedge clk);
    bus.mem_req = 1; bus.mem_we = 0; bus.mem_addr = 32'h40; bus.mem_size = 2'b10;
    bus.if_req = 1; bus.if_addr = 32'h104;
    md = 0; id = 0; stops = 0; starts = 0;
    for (int c = 1; c <= 30 && (md == 0 || id == 0); c++) begin
      @(negedge clk);
      stops += int'(bus.stallreq_stop);
      starts += int'(bus.stallreq_start);
      if (bus.mem_done) begin md = c; bus.mem_req = 0; check("both mem_rdata", bus.mem_rdata, 32'hDEADBEEF); end
      if (bus.if_done) begin id = c; bus.if_req = 0; check("both if_inst", bus.if_inst, ref_read(17'h104, 4)); end
    end
    bus.mem_req = 0; bus.if_req = 0;
    check("both mem_done cycle", 32'(md), 6);
    check("both if_done cycle", 32'(id), 13);
    check("both stop pulses", 32'(stops), 2);
    check("both start pulses", 32'(starts), 2);
    exp_last_rdata = 32'hDEADBEEF; exp_last_inst = ref_read(17'h104, 4); last_ram_a = 17'h107;
`ifdef MEM_ARBITER_IFETCH_BUF_EN
    m_buf_valid = 1'b1; m_buf_addr = 17'h104;
`endif

    // reset in cycle 2 of a word store
    @(negedge clk);
    bus.mem_req = 1; bus.mem_we = 1; bus.mem_addr = 32'h300; bus.mem_size = 2'b10;
    bus.mem_wdata = 32'h11223344;
    @(negedge clk);
    @(posedge clk); #2 rst = 1'b0; #1;
    check("rst ram_wr drop", 32'(bus.ram_wr), 0);
    bus.mem_req = 0;
    repeat (2) begin @(negedge clk); check("rst no done", 32'(bus.mem_done), 0); end
    check("rst partial byte0", 32'(ram[17'h300]), 32'h44);
    check("rst byte1 untouched", 32'(ram[17'h301]), 32'(ref_mem[17'h301]));
    ref_mem[17'h300] = 8'h44;
    rst = 1'b1;
    @(negedge clk);
    check_zero("post reset");
    exp_last_rdata = 0; exp_last_inst = 0; last_ram_a = 0;
`ifdef MEM_ARBITER_IFETCH_BUF_EN
    m_buf_valid = 1'b0;
`endif
    apply("after reset load", 1, 0, 32'h300, 2'b10, 0, ref_read(17'h300, 4), 6);

`ifdef MEM_ARBITER_IFETCH_BUF_EN
    apply("buf fill", 0, 0, 32'h100, 2'b10, 0, 32'h00100513, 6);
    apply("buf hit", 0, 0, 32'h100, 2'b10, 0, 32'h00100513, 1);
    apply("buf store", 1, 1, 32'h102, 2'b00, 32'h77, 0, 2);
    apply("buf refetch", 0, 0, 32'h100, 2'b10, 0, 32'h00770513, 6);
`endif

    // randomized traffic against the memory model
    for (int t = 0; t < 300; t++) begin
      is_mem = 1'($urandom);
      we     = is_mem && 1'($urandom);
      size   = 2'($urandom);
      wdata  = $urandom;
      addr   = rand_addr();
      if (!is_mem && $urandom_range(0, 2) == 0) addr = last_if_addr;
      if (!is_mem) last_if_addr = addr;
      a    = addr[ADDR_W-1:0];
      n    = is_mem ? nbytes(size) : 4;
      hit  = predict_hit(is_mem, a);
      expd = we ? 32'h0 : ref_read(a, n);
      apply($sformatf("rnd%0d", t), is_mem, we, addr, size, wdata, expd,
            hit ? 1 : (we ? n + 1 : n + 2));
    end

    wd = 0;
    @(negedge clk);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end
endmodule
